// File: rtl/imem_pkg.sv
// Shared types and widths for the instruction fetch unit.
// Used by imem_fetch and its entry buffer imem_fetch_fifo.
package imem_pkg;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 3;

  typedef enum logic {
    BOOT_WAIT,
    RUN
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] pc_inc(
    input logic [ADDR_W-1:0] pc
  );
    return pc + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/imem_fetch_fifo.sv
// Small FIFO of fetched {pc, instr} entries, DEPTH 2..4.
// Flush has priority over push and pop on the same edge.
module imem_fetch_fifo
  import imem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  fetch_entry_t     wdata,
  input  logic             pop,
  input  logic             flush,
  output fetch_entry_t     head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PTR_W'(1);
      if (do_pop)
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: empty gates its visibility.
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/imem_fetch.sv
// Instruction fetch from BSRAM into a small buffer, with redirect.
// Define IMEM_FETCH_BYPASS_EN to forward read data straight to instr.
module imem_fetch
  import imem_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 11'd0,
  parameter int                DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              boot_busy,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_target,
  input  logic              instr_ready,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              mem_ce,
  output logic [ADDR_W-1:0] mem_ad,
  input  logic [DATA_W-1:0] mem_dout
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;

  fetch_entry_t      head;
  fetch_entry_t      wdata;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;

  logic              pop;
  logic              push;
  logic              issue;
  logic              room;
  logic [CNT_W:0]    occ;

  assign pop   = instr_valid & instr_ready;
  assign wdata = '{pc: inflight_pc, instr: mem_dout};

  // Occupancy after this edge if nothing new were issued.
  assign occ = {1'b0, count}
             + (CNT_W+1)'(inflight)
             - (CNT_W+1)'(pop);

  assign room  = (~full | pop) & (occ < (CNT_W+1)'(DEPTH));
  assign issue = (state == RUN) & ~boot_busy & ~pc_load & room;

  assign mem_ce = issue;
  assign mem_ad = fetch_pc;

`ifdef IMEM_FETCH_BYPASS_EN
  logic live;

  // A read being killed by this edge's redirect is not live.
  assign live = inflight & ~pc_load;
  assign push = live & ~(empty & instr_ready);

  always_comb begin
    instr_valid = ~empty | live;
    instr       = '0;
    instr_pc    = RESET_PC;
    if (!empty) begin
      instr    = head.instr;
      instr_pc = head.pc;
    end else if (live) begin
      instr    = mem_dout;
      instr_pc = inflight_pc;
    end
  end
`else
  assign push = inflight & ~pc_load;

  always_comb begin
    instr_valid = ~empty;
    instr       = '0;
    instr_pc    = RESET_PC;
    if (!empty) begin
      instr    = head.instr;
      instr_pc = head.pc;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= BOOT_WAIT;
      fetch_pc    <= RESET_PC;
      inflight_pc <= RESET_PC;
      inflight    <= 1'b0;
    end else begin
      unique case (state)
        BOOT_WAIT: if (!boot_busy) state <= RUN;
        RUN:       if (boot_busy)  state <= BOOT_WAIT;
        default:   state <= BOOT_WAIT;
      endcase
      // issue is low under pc_load, so a redirect also kills inflight.
      inflight <= issue;
      if (issue)
        inflight_pc <= fetch_pc;
      if (pc_load)
        fetch_pc <= pc_target;
      else if (issue)
        fetch_pc <= pc_inc(fetch_pc);
    end
  end

  imem_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .flush (pc_load),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

endmodule

// File: tb/tb_imem_fetch.sv
// Scoreboard bench for imem_fetch with a 1-cycle BSRAM model.
// Expected pcs are queued at stimulus time and popped on accept.
module tb_imem_fetch;
  import imem_pkg::*;

  localparam logic [10:0] RESET_PC = 11'd0;
  localparam int DEPTH = 3;
`ifdef IMEM_FETCH_BYPASS_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        boot_busy = 1'b1;
  logic        pc_load = 1'b0;
  logic [10:0] pc_target = '0;
  logic        instr_ready = 1'b0;
  logic        instr_valid;
  logic [15:0] instr;
  logic [10:0] instr_pc;
  logic        mem_ce;
  logic [10:0] mem_ad;
  logic [15:0] mem_dout = '0;

  logic [15:0] rom [2048];
  logic [10:0] sbq [$];
  logic [10:0] exp_pc;
  int vectors = 0;
  int errors = 0;

  imem_fetch #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .boot_busy   (boot_busy),
    .pc_load     (pc_load),
    .pc_target   (pc_target),
    .instr_ready (instr_ready),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .mem_ce      (mem_ce),
    .mem_ad      (mem_ad),
    .mem_dout    (mem_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_ce) mem_dout <= rom[mem_ad];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [10:0] t);
    tick();
    pc_load = 1'b1;
    pc_target = t;
    tick();
    pc_load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    boot_busy = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    vectors++;
    if (instr_valid !== 1'b0) begin
      errors++; $display("FAIL rst_valid: got %b want 0", instr_valid);
    end
    vectors++;
    if (mem_ce !== 1'b0) begin
      errors++; $display("FAIL rst_ce: got %b want 0", mem_ce);
    end
    vectors++;
    if (mem_ad !== RESET_PC) begin
      errors++; $display("FAIL rst_ad: got %h want %h", mem_ad, RESET_PC);
    end
    vectors++;
    if (instr !== 16'h0000) begin
      errors++; $display("FAIL rst_instr: got %h want 0000", instr);
    end
    vectors++;
    if (instr_pc !== RESET_PC) begin
      errors++; $display("FAIL rst_pc: got %h want %h", instr_pc, RESET_PC);
    end
  endtask

  task automatic test_boot();
    instr_ready = 1'b1;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (mem_ce !== 1'b0 || instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL boot_idle: ce=%b valid=%b want 0/0", mem_ce, instr_valid);
      end
      tick();
    end
    boot_busy = 1'b0;
    sbq.push_back(11'd0);
    sbq.push_back(11'd1);
    sbq.push_back(11'd2);
    for (int c = 0; c < 20 && sbq.size() > 0; c++) begin
      @(negedge clk);
      if (c <= LAT + 2) begin
        vectors++;
        if (instr_valid !== (c >= LAT)) begin
          errors++;
          $display("FAIL boot_lat c=%0d: valid=%b want %b", c, instr_valid, c >= LAT);
        end
      end
      if (instr_valid && instr_ready && !pc_load) begin
        exp_pc = sbq.pop_front();
        vectors++;
        if (instr_pc !== exp_pc || instr !== rom[exp_pc]) begin
          errors++;
          $display("FAIL boot_word: pc=%h instr=%h want pc=%h instr=%h",
                   instr_pc, instr, exp_pc, rom[exp_pc]);
        end
      end
      tick();
    end
    vectors++;
    if (sbq.size() != 0) begin
      errors++; $display("FAIL boot_timeout: %0d left want 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_backpressure();
    tick();
    instr_ready = 1'b0;
    pc_load = 1'b1;
    pc_target = 11'd500;
    tick();
    pc_load = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      vectors++;
      if (mem_ce !== (k < DEPTH)) begin
        errors++; $display("FAIL bp_ce k=%0d: got %b want %b", k, mem_ce, k < DEPTH);
      end
      tick();
    end
    @(negedge clk);
    vectors++;
    if (dut.u_fifo.count !== 3'(DEPTH) || instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_full: count=%0d valid=%b want %0d/1",
               dut.u_fifo.count, instr_valid, DEPTH);
    end
    for (int i = 0; i < DEPTH + 4; i++)
      sbq.push_back(11'(500 + i));
    tick();
    instr_ready = 1'b1;
    for (int c = 0; c < 30 && sbq.size() > 0; c++) begin
      @(negedge clk);
      if (instr_valid && instr_ready && !pc_load) begin
        exp_pc = sbq.pop_front();
        vectors++;
        if (instr_pc !== exp_pc || instr !== rom[exp_pc]) begin
          errors++;
          $display("FAIL bp_word: pc=%h instr=%h want pc=%h instr=%h",
                   instr_pc, instr, exp_pc, rom[exp_pc]);
        end
      end
      tick();
    end
    vectors++;
    if (sbq.size() != 0) begin
      errors++; $display("FAIL bp_timeout: %0d left want 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_jump();
    instr_ready = 1'b1;
    redirect(11'd0);
    tick();
    tick();
    @(negedge clk);
    vectors++;
    if (mem_ce !== 1'b1 || mem_ad !== 11'd2) begin
      errors++; $display("FAIL jump_setup: ce=%b ad=%h want 1/002", mem_ce, mem_ad);
    end
    tick();
    pc_load = 1'b1;
    pc_target = 11'd1;
    @(negedge clk);
    vectors++;
    if (instr_valid && instr_pc == 11'd2) begin
      errors++; $display("FAIL jump_kill_now: pc=%h presented want not 002", instr_pc);
    end
    tick();
    pc_load = 1'b0;
    for (int i = 1; i <= 4; i++)
      sbq.push_back(11'(i));
    for (int c = 0; c < 20 && sbq.size() > 0; c++) begin
      @(negedge clk);
      if (c <= LAT - 1) begin
        vectors++;
        if (instr_valid !== (c == LAT - 1)) begin
          errors++;
          $display("FAIL jump_lat c=%0d: valid=%b want %b", c, instr_valid, c == LAT - 1);
        end
      end
      if (instr_valid && instr_ready && !pc_load) begin
        exp_pc = sbq.pop_front();
        vectors++;
        if (instr_pc !== exp_pc || instr !== rom[exp_pc]) begin
          errors++;
          $display("FAIL jump_word: pc=%h instr=%h want pc=%h instr=%h",
                   instr_pc, instr, exp_pc, rom[exp_pc]);
        end
      end
      tick();
    end
    vectors++;
    if (sbq.size() != 0) begin
      errors++; $display("FAIL jump_timeout: %0d left want 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_wrap();
    instr_ready = 1'b1;
    redirect(11'd2046);
    sbq.push_back(11'd2046);
    sbq.push_back(11'd2047);
    sbq.push_back(11'd0);
    sbq.push_back(11'd1);
    for (int c = 0; c < 20 && sbq.size() > 0; c++) begin
      @(negedge clk);
      if (c == LAT - 1) begin
        vectors++;
        if (instr_valid !== 1'b1) begin
          errors++; $display("FAIL wrap_lat: valid=%b want 1", instr_valid);
        end
      end
      if (instr_valid && instr_ready && !pc_load) begin
        exp_pc = sbq.pop_front();
        vectors++;
        if (instr_pc !== exp_pc || instr !== rom[exp_pc]) begin
          errors++;
          $display("FAIL wrap_word: pc=%h instr=%h want pc=%h instr=%h",
                   instr_pc, instr, exp_pc, rom[exp_pc]);
        end
      end
      tick();
    end
    vectors++;
    if (sbq.size() != 0) begin
      errors++; $display("FAIL wrap_timeout: %0d left want 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_back_to_back();
    redirect(11'd300);
    for (int i = 0; i < 40; i++)
      sbq.push_back(11'(300 + i));
    for (int c = 0; c < 400 && sbq.size() > 0; c++) begin
      instr_ready = 1'($urandom_range(0, 1));
      boot_busy = (c >= 10 && c < 15);
      @(negedge clk);
      if (boot_busy) begin
        vectors++;
        if (mem_ce !== 1'b0) begin
          errors++; $display("FAIL b2b_busy_ce c=%0d: got %b want 0", c, mem_ce);
        end
      end
      if (instr_valid && instr_ready && !pc_load) begin
        exp_pc = sbq.pop_front();
        vectors++;
        if (instr_pc !== exp_pc || instr !== rom[exp_pc]) begin
          errors++;
          $display("FAIL b2b_word: pc=%h instr=%h want pc=%h instr=%h",
                   instr_pc, instr, exp_pc, rom[exp_pc]);
        end
      end
      tick();
    end
    boot_busy = 1'b0;
    vectors++;
    if (sbq.size() != 0) begin
      errors++; $display("FAIL b2b_timeout: %0d left want 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_reset_mid();
    instr_ready = 1'b0;
    redirect(11'd700);
    repeat (3) tick();
    @(negedge clk);
    vectors++;
    if (dut.u_fifo.count !== 3'd2 || dut.inflight !== 1'b1) begin
      errors++;
      $display("FAIL rmid_setup: count=%0d inflight=%b want 2/1",
               dut.u_fifo.count, dut.inflight);
    end
    #1;
    rst = 1'b0;
    #1;
    vectors++;
    if (instr_valid !== 1'b0 || mem_ce !== 1'b0) begin
      errors++; $display("FAIL rmid_now: valid=%b ce=%b want 0/0", instr_valid, mem_ce);
    end
    tick();
    instr_ready = 1'b1;
    tick();
    rst = 1'b1;
    sbq.push_back(RESET_PC);
    sbq.push_back(RESET_PC + 11'd1);
    for (int c = 0; c < 20 && sbq.size() > 0; c++) begin
      @(negedge clk);
      if (c <= LAT) begin
        vectors++;
        if (instr_valid !== (c == LAT)) begin
          errors++;
          $display("FAIL rmid_lat c=%0d: valid=%b want %b", c, instr_valid, c == LAT);
        end
      end
      if (instr_valid && instr_ready && !pc_load) begin
        exp_pc = sbq.pop_front();
        vectors++;
        if (instr_pc !== exp_pc || instr !== rom[exp_pc]) begin
          errors++;
          $display("FAIL rmid_word: pc=%h instr=%h want pc=%h instr=%h",
                   instr_pc, instr, exp_pc, rom[exp_pc]);
        end
      end
      tick();
    end
    vectors++;
    if (sbq.size() != 0) begin
      errors++; $display("FAIL rmid_timeout: %0d left want 0", sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++)
      rom[i] = 16'((i * 40503) ^ 16'h5a3c);
    rom[0] = 16'h0000;
    rom[1] = 16'hA1A1;
    rom[2] = 16'h9191;
    test_reset();
    test_boot();
    test_backpressure();
    test_jump();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
